// File: rtl/ov7670_capture.sv
// OV7670 capture: syncs the camera bus into sys_clk and pairs bytes into RGB565.
// Ports: sys_clk/sys_rst; cam_* camera bus; capture_en; wr_* frame-buffer write; frame_done/frame_cnt/line_err status.
module ov7670_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIMATE = 1,
  parameter int ADDR_W   = 17
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              capture_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic [7:0]        frame_cnt,
  output logic              line_err
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] H_MAX = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_MAX = YW'(V_ACTIVE);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [2:0]        pclk_q;
  logic [2:0]        vsync_q;
  logic [2:0]        href_q;
  logic [7:0]        data_q1;
  logic [7:0]        data_q2;

  logic [1:0]        state;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] addr;
  logic              phase;
  logic [7:0]        hi;

  logic pclk_rise;
  logic vsync_rise;
  logic vsync_fall;
  logic href_fall;
  logic href_on;
  logic wr_ok;

  // Bit 1 is the synchronized value; bit 2 is the delayed copy for edges.
  // href/data are used at the same depth as pclk so they line up with pclk_rise.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pclk_q  <= '0;
      vsync_q <= '0;
      href_q  <= '0;
      data_q1 <= '0;
      data_q2 <= '0;
    end else begin
      pclk_q  <= {pclk_q[1:0], cam_pclk};
      vsync_q <= {vsync_q[1:0], cam_vsync};
      href_q  <= {href_q[1:0], cam_href};
      data_q1 <= cam_data;
      data_q2 <= data_q1;
    end
  end

  assign pclk_rise  = pclk_q[1] & ~pclk_q[2];
  assign vsync_rise = vsync_q[1] & ~vsync_q[2];
  assign vsync_fall = ~vsync_q[1] & vsync_q[2];
  assign href_fall  = ~href_q[1] & href_q[2];
  assign href_on    = href_q[1];

  assign wr_ok = (x < H_MAX) && (y < V_MAX) &&
                 ((DECIMATE == 0) || (!x[0] && !y[0]));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      phase      <= 1'b0;
      hi         <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      line_err   <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (capture_en) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!capture_en) begin
            state <= S_IDLE;
          end else if (vsync_fall) begin
            x     <= '0;
            y     <= '0;
            addr  <= '0;
            phase <= 1'b0;
            state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (pclk_rise && href_on) begin
            if (!phase) begin
              hi    <= data_q2;
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x < H_MAX) x <= x + 1'b1;
              if (wr_ok) begin
                wr_en   <= 1'b1;
                wr_data <= {hi, data_q2};
                wr_addr <= addr;
                addr    <= addr + 1'b1;
              end
            end
          end
          // href_fall and pclk_rise with href high are mutually exclusive.
          if (href_fall) begin
            x     <= '0;
            phase <= 1'b0;
            if (y < V_MAX) y <= y + 1'b1;
            if (phase) line_err <= 1'b1;
          end
          if (vsync_rise) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 8'd1;
            state      <= capture_en ? S_WAIT : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: full-rate 4x2 instance (a) and decimating 4x4 instance (b).
// Directed frames from a scenario table plus hand-written enable/reset/wrap sequences.
module tb_ov7670_capture;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        en_a;
  logic        en_b;

  logic        wa_en, wb_en;
  logic [16:0] wa_addr, wb_addr;
  logic [15:0] wa_data, wb_data;
  logic        fd_a, fd_b;
  logic [7:0]  fc_a, fc_b;
  logic        le_a, le_b;

  ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIMATE(0), .ADDR_W(17)) dut_a (
    .sys_clk(clk), .sys_rst(rst),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data),
    .capture_en(en_a),
    .wr_en(wa_en), .wr_addr(wa_addr), .wr_data(wa_data),
    .frame_done(fd_a), .frame_cnt(fc_a), .line_err(le_a)
  );

  ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(4), .DECIMATE(1), .ADDR_W(17)) dut_b (
    .sys_clk(clk), .sys_rst(rst),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data),
    .capture_en(en_b),
    .wr_en(wb_en), .wr_addr(wb_addr), .wr_data(wb_data),
    .frame_done(fd_b), .frame_cnt(fc_b), .line_err(le_b)
  );

  typedef struct {
    logic [16:0] addr;
    logic [15:0] data;
    int          lat;
  } wr_t;

  typedef struct {
    string       name;
    int          sel;
    int          lines;
    int          nb0;
    int          nb;
    int          mode;
    int          hook;
    int          n_wr;
    int          n_le;
    logic [16:0] last_a;
    logic [15:0] last_d;
  } sc_t;

  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  last_rise = 0;
  wr_t qa[$];
  wr_t qb[$];
  wr_t eq[$];
  int  nfd_a, nfd_b, nle_a, nle_b;
  int  cnt_a = 0;
  int  cnt_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Collect strobes; latency is measured from the bench's last second-byte pclk rise.
  always @(negedge clk) begin
    if (!rst) begin
      if (wa_en) qa.push_back('{wa_addr, wa_data, cyc - last_rise});
      if (wb_en) qb.push_back('{wb_addr, wb_data, cyc - last_rise});
      if (fd_a) nfd_a = nfd_a + 1;
      if (fd_b) nfd_b = nfd_b + 1;
      if (le_a) nle_a = nle_a + 1;
      if (le_b) nle_b = nle_b + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pbyte(input int mode, input int y, input int i);
    if (mode == 0) return (i % 2 == 1) ? 8'h00 : 8'hF8;
    return (i % 2 == 1) ? 8'(i / 2) : 8'(y);
  endfunction

  task automatic cam_byte(input logic [7:0] b, input bit lo);
    @(negedge clk);
    cam_pclk = 1'b0;
    cam_data = b;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    if (lo) last_rise = cyc;
    @(negedge clk);
  endtask

  // hook: 1 = drop enables at line 1, 2 = reset at line 1,
  // 3 = vsync rises together with the last href fall.
  task automatic frame(input int lines, input int nb0, input int nb,
                       input int mode, input int hook);
    @(negedge clk);
    cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
    for (int y = 0; y < lines; y++) begin
      if (hook == 1 && y == 1) begin
        en_a = 1'b0;
        en_b = 1'b0;
      end
      if (hook == 2 && y == 1) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      cam_href = 1'b1;
      for (int i = 0; i < ((y == 0) ? nb0 : nb); i++)
        cam_byte(pbyte(mode, y, i), i % 2 == 1);
      @(negedge clk);
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      if (hook == 3 && y == lines - 1) cam_vsync = 1'b1;
      repeat (4) @(negedge clk);
    end
    cam_vsync = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic build(input int h, input int v, input int d, input int lines,
                       input int nb0, input int nb, input int mode);
    int a;
    int n;
    a = 0;
    eq.delete();
    for (int y = 0; y < lines; y++) begin
      n = (y == 0) ? nb0 : nb;
      for (int x = 0; x < n / 2; x++) begin
        if (x < h && y < v && (d == 0 || (x % 2 == 0 && y % 2 == 0))) begin
          eq.push_back('{17'(a), {pbyte(mode, y, 2 * x), pbyte(mode, y, 2 * x + 1)}, 3});
          a++;
        end
      end
    end
  endtask

  task automatic clear_mon();
    qa.delete();
    qb.delete();
    nfd_a = 0;
    nfd_b = 0;
    nle_a = 0;
    nle_b = 0;
  endtask

  sc_t tab[6];

  initial begin
    tab[0] = '{"full",     0, 2, 8,  8,  0, 0, 8, 0, 17'd7, 16'hF800};
    tab[1] = '{"decim",    1, 4, 8,  8,  1, 0, 4, 0, 17'd3, 16'h0202};
    tab[2] = '{"oddline",  0, 2, 7,  8,  1, 0, 7, 1, 17'd6, 16'h0103};
    tab[3] = '{"oversize", 0, 3, 12, 12, 1, 0, 8, 0, 17'd7, 16'h0103};
    tab[4] = '{"vs_hf",    0, 2, 8,  7,  1, 3, 7, 1, 17'd6, 16'h0102};
    tab[5] = '{"en_drop",  0, 2, 8,  8,  0, 1, 8, 0, 17'd7, 16'hF800};

    rst       = 1'b1;
    en_a      = 1'b1;
    en_b      = 1'b1;
    cam_pclk  = 1'b0;
    cam_vsync = 1'b1;
    cam_href  = 1'b0;
    cam_data  = 8'h00;
    clear_mon();

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cam_pclk  = ~cam_pclk;
      cam_href  = ~cam_href;
      cam_vsync = ~cam_vsync;
      cam_data  = cam_data + 8'h35;
      chk("rst_wr_en",  int'(wa_en | wb_en), 0);
      chk("rst_fdone",  int'(fd_a | fd_b), 0);
      chk("rst_lerr",   int'(le_a | le_b), 0);
      chk("rst_fcnt",   int'(fc_a | fc_b), 0);
      chk("rst_waddr",  int'(wa_addr | wb_addr), 0);
    end
    @(negedge clk);
    rst       = 1'b0;
    en_a      = 1'b0;
    en_b      = 1'b0;
    cam_pclk  = 1'b0;
    cam_href  = 1'b0;
    cam_vsync = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_strobes", qa.size() + qb.size(), 0);

    for (int s = 0; s < 6; s++) begin
      clear_mon();
      if (tab[s].sel == 0) begin
        en_a = 1'b1;
        build(4, 2, 0, tab[s].lines, tab[s].nb0, tab[s].nb, tab[s].mode);
      end else begin
        en_b = 1'b1;
        build(4, 4, 1, tab[s].lines, tab[s].nb0, tab[s].nb, tab[s].mode);
      end
      repeat (3) @(negedge clk);
      frame(tab[s].lines, tab[s].nb0, tab[s].nb, tab[s].mode, tab[s].hook);
      en_a = 1'b0;
      en_b = 1'b0;
      repeat (3) @(negedge clk);
      if (tab[s].sel == 0) begin
        cnt_a++;
        chk({tab[s].name, "_nwr"}, qa.size(), tab[s].n_wr);
        chk({tab[s].name, "_model_n"}, qa.size(), eq.size());
        chk({tab[s].name, "_other"}, qb.size(), 0);
        for (int i = 0; i < qa.size() && i < eq.size(); i++) begin
          chk($sformatf("%s_addr%0d", tab[s].name, i), int'(qa[i].addr), int'(eq[i].addr));
          chk($sformatf("%s_data%0d", tab[s].name, i), int'(qa[i].data), int'(eq[i].data));
          chk($sformatf("%s_lat%0d", tab[s].name, i), qa[i].lat, eq[i].lat);
        end
        if (qa.size() > 0) begin
          chk({tab[s].name, "_last_a"}, int'(qa[$].addr), int'(tab[s].last_a));
          chk({tab[s].name, "_last_d"}, int'(qa[$].data), int'(tab[s].last_d));
        end
        chk({tab[s].name, "_lerr"}, nle_a, tab[s].n_le);
        chk({tab[s].name, "_fdone"}, nfd_a, 1);
        chk({tab[s].name, "_fcnt"}, int'(fc_a), cnt_a);
      end else begin
        cnt_b++;
        chk({tab[s].name, "_nwr"}, qb.size(), tab[s].n_wr);
        chk({tab[s].name, "_model_n"}, qb.size(), eq.size());
        chk({tab[s].name, "_other"}, qa.size(), 0);
        for (int i = 0; i < qb.size() && i < eq.size(); i++) begin
          chk($sformatf("%s_addr%0d", tab[s].name, i), int'(qb[i].addr), int'(eq[i].addr));
          chk($sformatf("%s_data%0d", tab[s].name, i), int'(qb[i].data), int'(eq[i].data));
          chk($sformatf("%s_lat%0d", tab[s].name, i), qb[i].lat, eq[i].lat);
        end
        if (qb.size() > 0) begin
          chk({tab[s].name, "_last_a"}, int'(qb[$].addr), int'(tab[s].last_a));
          chk({tab[s].name, "_last_d"}, int'(qb[$].data), int'(tab[s].last_d));
        end
        chk({tab[s].name, "_lerr"}, nle_b, tab[s].n_le);
        chk({tab[s].name, "_fdone"}, nfd_b, 1);
        chk({tab[s].name, "_fcnt"}, int'(fc_b), cnt_b);
      end
    end

    // After the enable was dropped mid-frame the block must sit in IDLE.
    clear_mon();
    frame(2, 8, 8, 0, 0);
    chk("idle_after_drop_wr", qa.size(), 0);
    chk("idle_after_drop_fd", nfd_a, 0);

    // Enable withdrawn while waiting for the frame start.
    clear_mon();
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    en_a = 1'b0;
    repeat (3) @(negedge clk);
    frame(2, 8, 8, 0, 0);
    chk("en_low_wr", qa.size(), 0);
    chk("en_low_fd", nfd_a, 0);
    chk("en_low_fcnt", int'(fc_a), cnt_a);

    // Reset at the start of line 1: only line 0 is written, nothing after.
    clear_mon();
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    frame(2, 8, 8, 0, 2);
    cnt_a = 0;
    cnt_b = 0;
    chk("midrst_wr", qa.size(), 4);
    chk("midrst_fd", nfd_a, 0);
    chk("midrst_fcnt", int'(fc_a), cnt_a);
    chk("midrst_wr_en", int'(wa_en), 0);
    en_a = 1'b0;
    repeat (3) @(negedge clk);

    // frame_cnt wrap: 256 empty frames.
    clear_mon();
    en_a = 1'b1;
    repeat (3) @(negedge clk);
    for (int f = 0; f < 256; f++) begin
      frame(0, 0, 0, 0, 0);
      if (f == 254) chk("wrap_255", int'(fc_a), 255);
    end
    chk("wrap_0", int'(fc_a), 0);
    chk("wrap_fdone", nfd_a, 256);
    chk("wrap_wr", qa.size(), 0);
    en_a = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
